// File: rtl/mips_exec_core.sv
// Single-cycle MIPS-subset execute core: decode, ALU, PC adders, next-PC and write-back selection.
// Only pc is registered; every other output settles combinationally within the cycle, and there is no backpressure.
module mips_exec_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic [31:0] mem_rd,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_next,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic        reg_write,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   output logic        mem_write,
   output logic [4:0]  alu_control
);

   localparam logic [4:0] ALU_AND  = 5'b00000, ALU_OR   = 5'b00001, ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_XOR  = 5'b00011, ALU_NOR  = 5'b00100, ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_SLT  = 5'b00111, ALU_SLTU = 5'b01000, ALU_SLL = 5'b01001;
   localparam logic [4:0] ALU_SRL  = 5'b01010, ALU_SRA  = 5'b01011, ALU_LUI = 5'b01100;

   typedef struct packed {
      logic       rw;
      logic       mw;
      logic [4:0] alu;
      logic       use_imm;
      logic       zero_ext;
      logic       shift;
      logic       dst_rd;
      logic       jr;
      logic       jmp;
      logic       link;
      logic       load;
      logic       beq;
      logic       bne;
   } ctrl_t;

   ctrl_t       ctrl;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] sign_imm;
   logic [31:0] zero_imm;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] branch_target;
   logic        take_branch;

   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];
   assign sign_imm = {{16{instr[15]}}, instr[15:0]};
   assign zero_imm = {16'h0000, instr[15:0]};

   always_comb begin
      ctrl     = '0;
      ctrl.alu = ALU_ADD;
      case (opcode)
         6'h00: begin
            ctrl.dst_rd = 1'b1;
            case (funct)
               6'h20, 6'h21: begin ctrl.rw = 1'b1; ctrl.alu = ALU_ADD;  end
               6'h22, 6'h23: begin ctrl.rw = 1'b1; ctrl.alu = ALU_SUB;  end
               6'h24:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_AND;  end
               6'h25:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_OR;   end
               6'h26:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_XOR;  end
               6'h27:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_NOR;  end
               6'h2A:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_SLT;  end
               6'h2B:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_SLTU; end
               6'h00:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_SLL; ctrl.shift = 1'b1; end
               6'h02:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_SRL; ctrl.shift = 1'b1; end
               6'h03:        begin ctrl.rw = 1'b1; ctrl.alu = ALU_SRA; ctrl.shift = 1'b1; end
               6'h08:        ctrl.jr = 1'b1;
               default:      ;
            endcase
         end
         6'h08, 6'h09: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.alu = ALU_ADD; end
         6'h0C: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu = ALU_AND; end
         6'h0D: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu = ALU_OR;  end
         6'h0E: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu = ALU_XOR; end
         6'h0A: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.alu = ALU_SLT;  end
         6'h0B: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.alu = ALU_SLTU; end
         6'h0F: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.alu = ALU_LUI;  end
         6'h23: begin ctrl.rw = 1'b1; ctrl.use_imm = 1'b1; ctrl.load = 1'b1; end
         6'h2B: begin ctrl.mw = 1'b1; ctrl.use_imm = 1'b1; end
         6'h04: begin ctrl.beq = 1'b1; ctrl.alu = ALU_SUB; end
         6'h05: begin ctrl.bne = 1'b1; ctrl.alu = ALU_SUB; end
         6'h02: ctrl.jmp = 1'b1;
         6'h03: begin ctrl.jmp = 1'b1; ctrl.link = 1'b1; ctrl.rw = 1'b1; end
         default: ;
      endcase
   end

   // Shifts take their amount from shamt on the A side so B stays the shifted value.
   assign src_a = ctrl.shift ? {27'd0, instr[10:6]} : rd1;
   assign src_b = ctrl.use_imm ? (ctrl.zero_ext ? zero_imm : sign_imm) : rd2;

   always_comb begin
      alu_result = 32'd0;
      case (ctrl.alu)
         ALU_AND:  alu_result = src_a & src_b;
         ALU_OR:   alu_result = src_a | src_b;
         ALU_ADD:  alu_result = src_a + src_b;
         ALU_XOR:  alu_result = src_a ^ src_b;
         ALU_NOR:  alu_result = ~(src_a | src_b);
         ALU_SUB:  alu_result = src_a - src_b;
         ALU_SLT:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
         ALU_SLTU: alu_result = {31'd0, src_a < src_b};
         ALU_SLL:  alu_result = src_b << src_a[4:0];
         ALU_SRL:  alu_result = src_b >> src_a[4:0];
         ALU_SRA:  alu_result = $signed(src_b) >>> src_a[4:0];
         ALU_LUI:  alu_result = src_b << 16;
         default:  alu_result = 32'd0;
      endcase
   end

   assign zero          = (alu_result == 32'd0);
   assign alu_control   = ctrl.alu;
   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + {sign_imm[29:0], 2'b00};
   assign take_branch   = (ctrl.beq & zero) | (ctrl.bne & ~zero);

   always_comb begin
      if (ctrl.jr)
         pc_next = rd1;
      else if (ctrl.jmp)
         pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (take_branch)
         pc_next = branch_target;
      else
         pc_next = pc_plus4;
   end

   assign write_reg  = ctrl.link ? 5'd31 : (ctrl.dst_rd ? instr[15:11] : instr[20:16]);
   assign write_data = ctrl.link ? pc_plus4 : (ctrl.load ? mem_rd : alu_result);
   assign reg_write  = ctrl.rw & reset_n;
   assign mem_write  = ctrl.mw & reset_n;

   always_ff @(posedge clock) begin
      if (!reset_n)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed bench for mips_exec_core: expectations are queued as each instruction is driven and checked mid-cycle.
module tb_mips_exec_core;

   localparam int S_PC = 0, S_PP4 = 1, S_NEXT = 2, S_ALU = 3, S_ZERO = 4;
   localparam int S_RW = 5, S_WREG = 6, S_WDAT = 7, S_MW = 8, S_CTL = 9;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] instr, rd1, rd2, mem_rd;
   logic [31:0] pc, pc_plus4, pc_next, alu_result, write_data;
   logic        zero, reg_write, mem_write;
   logic [4:0]  write_reg, alu_control;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] pc_m;

   mips_exec_core #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset_n(reset_n), .instr(instr), .rd1(rd1), .rd2(rd2), .mem_rd(mem_rd),
      .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next), .alu_result(alu_result), .zero(zero),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .mem_write(mem_write), .alu_control(alu_control)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_PC:    return pc;
         S_PP4:   return pc_plus4;
         S_NEXT:  return pc_next;
         S_ALU:   return alu_result;
         S_ZERO:  return {31'd0, zero};
         S_RW:    return {31'd0, reg_write};
         S_WREG:  return {27'd0, write_reg};
         S_WDAT:  return write_data;
         S_MW:    return {31'd0, mem_write};
         S_CTL:   return {27'd0, alu_control};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   // Drive one instruction; the current pc and pc+4 are always expected.
   task automatic drive(input logic rn, input logic [31:0] i, a, b, m);
      reset_n = rn;
      instr   = i;
      rd1     = a;
      rd2     = b;
      mem_rd  = m;
      expect_val("pc", S_PC, pc_m);
      expect_val("pc_plus4", S_PP4, pc_m + 32'd4);
   endtask

   // Check queued expectations mid-cycle, then clock the instruction and track the pc.
   task automatic retire(input logic [31:0] nxt);
      exp_t        e;
      logic [31:0] obs;
      expect_val("pc_next", S_NEXT, nxt);
      @(negedge clock);
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         compared++;
         assert (obs === e.exp)
         else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
      @(posedge clock);
      #1;
      pc_m = reset_n ? nxt : 32'h0000_0000;
   endtask

   initial begin
      reset_n = 1'b0;
      instr   = 32'hAC00_0000;
      rd1     = 32'd0;
      rd2     = 32'd0;
      mem_rd  = 32'd0;
      pc_m    = 32'h0000_0000;
      @(posedge clock);
      @(posedge clock);
      #1;

      // reset held with a store present
      drive(1'b0, 32'hAC00_0000, 32'd0, 32'd0, 32'd0);
      expect_val("rst_mem_write", S_MW, 32'd0);
      expect_val("rst_reg_write", S_RW, 32'd0);
      retire(32'h4);

      // add $8,$9,$10 : 7 + -3
      drive(1'b1, 32'h012A_4020, 32'd7, 32'hFFFF_FFFD, 32'd0);
      expect_val("add_ctl", S_CTL, 32'h02);
      expect_val("add_res", S_ALU, 32'd4);
      expect_val("add_wreg", S_WREG, 32'd8);
      expect_val("add_rw", S_RW, 32'd1);
      expect_val("add_wdat", S_WDAT, 32'd4);
      retire(32'h4);

      drive(1'b1, 32'h012A_402A, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_val("slt_ctl", S_CTL, 32'h07);
      expect_val("slt_res", S_ALU, 32'd1);
      retire(32'h8);

      drive(1'b1, 32'h012A_402B, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_val("sltu_ctl", S_CTL, 32'h08);
      expect_val("sltu_res", S_ALU, 32'd0);
      retire(32'hC);

      // lw $8,8($9)
      drive(1'b1, 32'h8D28_0008, 32'h100, 32'd0, 32'hDEAD_BEEF);
      expect_val("lw_addr", S_ALU, 32'h108);
      expect_val("lw_wdat", S_WDAT, 32'hDEAD_BEEF);
      expect_val("lw_wreg", S_WREG, 32'd8);
      expect_val("lw_rw", S_RW, 32'd1);
      expect_val("lw_mw", S_MW, 32'd0);
      retire(32'h10);

      // branches at 0x10 with offset -1 word
      drive(1'b1, 32'h112A_FFFF, 32'd5, 32'd5, 32'd0);
      expect_val("beq_eq_zero", S_ZERO, 32'd1);
      expect_val("beq_eq_ctl", S_CTL, 32'h06);
      expect_val("beq_eq_rw", S_RW, 32'd0);
      retire(32'h10);

      drive(1'b1, 32'h152A_FFFF, 32'd5, 32'd6, 32'd0);
      expect_val("bne_ne_zero", S_ZERO, 32'd0);
      retire(32'h10);

      drive(1'b1, 32'h112A_FFFF, 32'd5, 32'd6, 32'd0);
      retire(32'h14);

      drive(1'b1, 32'h0800_0004, 32'd0, 32'd0, 32'd0);
      expect_val("j_rw", S_RW, 32'd0);
      retire(32'h10);

      drive(1'b1, 32'h152A_FFFF, 32'd5, 32'd5, 32'd0);
      retire(32'h14);

      // sw $8,8($9)
      drive(1'b1, 32'hAD28_0008, 32'h100, 32'd0, 32'hDEAD_BEEF);
      expect_val("sw_addr", S_ALU, 32'h108);
      expect_val("sw_mw", S_MW, 32'd1);
      expect_val("sw_rw", S_RW, 32'd0);
      retire(32'h18);

      drive(1'b1, 32'h0800_0010, 32'd0, 32'd0, 32'd0);
      retire(32'h40);

      drive(1'b1, 32'h0C00_0100, 32'd0, 32'd0, 32'd0);
      expect_val("jal_wreg", S_WREG, 32'd31);
      expect_val("jal_wdat", S_WDAT, 32'h44);
      expect_val("jal_rw", S_RW, 32'd1);
      retire(32'h400);

      drive(1'b1, 32'h03E0_0008, 32'h44, 32'd0, 32'd0);
      expect_val("jr_rw", S_RW, 32'd0);
      retire(32'h44);

      // unknown opcode acts as a nop
      drive(1'b1, 32'hFC00_0000, 32'h1234, 32'h5678, 32'd0);
      expect_val("nop_rw", S_RW, 32'd0);
      expect_val("nop_mw", S_MW, 32'd0);
      expect_val("nop_ctl", S_CTL, 32'h02);
      retire(32'h48);

      // sra $8,$10,4
      drive(1'b1, 32'h000A_4103, 32'h0, 32'h8000_0000, 32'd0);
      expect_val("sra_ctl", S_CTL, 32'h0B);
      expect_val("sra_res", S_ALU, 32'hF800_0000);
      retire(32'h4C);

      // ori uses the zero-extended immediate
      drive(1'b1, 32'h3528_8001, 32'h1, 32'd0, 32'd0);
      expect_val("ori_res", S_ALU, 32'h0000_8001);
      expect_val("ori_wreg", S_WREG, 32'd8);
      retire(32'h50);

      // addi uses the sign-extended immediate
      drive(1'b1, 32'h2128_FFFF, 32'd5, 32'd0, 32'd0);
      expect_val("addi_res", S_ALU, 32'd4);
      retire(32'h54);

      // mid-run reset masks writes and reloads pc
      drive(1'b0, 32'h012A_4020, 32'd7, 32'd1, 32'd0);
      expect_val("rst2_rw", S_RW, 32'd0);
      retire(32'h58);

      drive(1'b1, 32'h012A_4020, 32'd1, 32'd2, 32'd0);
      expect_val("post_rst_res", S_ALU, 32'd3);
      retire(32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mips_exec_core.md
Name: mips_exec_core

Overview:
- Single-cycle MIPS-subset execute core: program counter register, main control decoder, 32-bit ALU, PC+4 adder and branch-target adder, next-PC selection and write-back data selection.
- Sits between instruction memory and register file/data memory in the single-cycle datapath. Fetch, register file and data memory stay external.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded during reset.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- instr  in  32  current instruction (fetched at pc).
- rd1  in  32  register-file read data for rs (instr[25:21]).
- rd2  in  32  register-file read data for rt (instr[20:16]).
- mem_rd  in  32  data-memory read data at alu_result.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc + 4.
- pc_next  out  32  value loaded into pc on the next edge.
- alu_result  out  32  ALU output; also the data-memory address.
- zero  out  1  alu_result == 0.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  destination register.
- write_data  out  32  register write-back data.
- mem_write  out  1  data-memory write enable. Write data is rd2.
- alu_control  out  5  decoded ALU operation.

Behaviour:
- Reset: on a rising clock edge with reset_n=0, pc <= RESET_PC. Whenever reset_n=0, reg_write=0 and mem_write=0. All other outputs remain combinational functions of inputs and pc.
- Normal operation: pc <= pc_next on every rising edge. Everything except pc is combinational, so each instruction takes one cycle.
- Immediates:
  - SignImm = sign-extend instr[15:0].
  - ZeroImm = zero-extend instr[15:0]. ZeroImm is used by andi, ori and xori. SignImm is used by all other immediate instructions.
- ALU operand selection:
  - SrcA = rd1. For sll, srl and sra, SrcA = zero-extended shamt (instr[10:6]).
  - SrcB = rd2 for R-type and branches; the selected immediate otherwise.
- alu_control encoding:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 NOR.
  - 00110 SUB; 00111 SLT (signed, result 1 or 0); 01000 SLTU.
  - 01001 SLL (B<<A[4:0]); 01010 SRL; 01011 SRA; 01100 LUI (B<<16).
  - Any other code yields result 0.
- ADD and SUB wrap modulo 2^32. Overflow is ignored and raises no exception.
- Decode, opcode=0 (R-type), selected by funct:
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA, with reg_write=1 and write_reg=rd (instr[15:11]).
  - funct 08 (jr): no write; pc_next = rd1.
- Decode, I-type opcodes (write_reg = rt):
  - 08/09 addi/addiu: ADD, reg_write=1.
  - 0C andi: AND, 0D ori: OR, 0E xori: XOR, all reg_write=1.
  - 0A slti: SLT, 0B sltiu: SLTU, both reg_write=1.
  - 0F lui: LUI, reg_write=1.
  - 23 lw: ADD, reg_write=1, write_data = mem_rd.
  - 2B sw: ADD, mem_write=1, no register write.
  - 04 beq / 05 bne: SUB, no write.
- Decode, J-type opcodes:
  - 02 j: no write.
  - 03 jal: reg_write=1, write_reg=31, write_data = pc_plus4.
- Unknown opcode or funct: behaves as a NOP. reg_write=0, mem_write=0, alu_control=00010, pc_next=pc_plus4.
- write_data: pc_plus4 for jal, mem_rd for lw, alu_result for everything else.
- Next PC, in priority order:
  1. jr -> rd1.
  2. j/jal -> {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. beq with zero=1, or bne with zero=0 -> pc_plus4 + (SignImm<<2).
  4. Otherwise -> pc_plus4.
- Both adders are 32-bit and wrap on carry-out. No alignment checking is performed on any PC source.
- Writes to register 0 are filtered by the register file, not by this block.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with instr=sw. Required: pc=0, mem_write=0, reg_write=0. Release reset_n, then one edge. Required: pc=4.
- R-type add, instr=0x012A4020 (add $8,$9,$10), rd1=7, rd2=-3. Required: alu_control=00010, alu_result=4, write_reg=8, reg_write=1, pc_next=pc+4.
- slt, rd1=0xFFFFFFFF, rd2=1. Required: alu_result=1 with SLT, 0 with SLTU.
- beq at pc=0x10, offset 0xFFFF. Equal operands: pc_next=0x10. Unequal operands: pc_next=0x14. bne with the same operands: the opposite outcomes.
- lw with rd1=0x100, imm=8, mem_rd=0xDEADBEEF. Required: alu_result=0x108, write_data=0xDEADBEEF. sw with the same operands: mem_write=1, reg_write=0.
- jal at pc=0x40, target field 0x100. Required: pc_next=0x400, write_reg=31, write_data=0x44. jr with rd1=0x44: pc_next=0x44, reg_write=0.
